traffic_phase_scheduler: RTL and testbench

//  Round-robin phase scheduler for an N-approach intersection; sits beside traffic_light_fsm under traffic_light_control.

---
 rtl/traffic_pkg.sv | 20 ++
 rtl/traffic_rr_picker.sv | 36 +++
 rtl/traffic_phase_scheduler.sv | 166 ++++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection phase scheduler and its
// sibling lamp controller.
package traffic_pkg;

    typedef enum logic [1:0] {
        ALLRED = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2
    } phase_e;

    // Per-approach lamp colour as a {green, yellow, red} one-hot triple.
    localparam logic [2:0] LAMP_RED    = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b100;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/traffic_rr_picker.sv
// Round-robin picker: first pending approach found searching upward from the
// one after last_grant, wrapping around.
module traffic_rr_picker #(
    parameter int NUM_APPROACH = 4,
    localparam int IDW = $clog2(NUM_APPROACH)
) (
    input  logic [NUM_APPROACH-1:0] pending,
    input  logic [IDW-1:0]          last_grant,
    output logic                    valid,
    output logic [IDW-1:0]          grant_idx
);

    logic [IDW-1:0]          cand [NUM_APPROACH];
    logic [NUM_APPROACH-1:0] hit;

    // cand[gi] is the approach (gi+1) positions after last_grant, modulo N.
    for (genvar gi = 0; gi < NUM_APPROACH; gi++) begin : g_cand
        logic [IDW:0] sum;
        assign sum      = {1'b0, last_grant} + (IDW+1)'(gi + 1);
        assign cand[gi] = (sum >= (IDW+1)'(NUM_APPROACH))
                        ? IDW'(sum - (IDW+1)'(NUM_APPROACH))
                        : IDW'(sum);
        assign hit[gi]  = pending[cand[gi]];
    end

    always_comb begin
        valid     = |hit;
        grant_idx = '0;
        for (int i = NUM_APPROACH - 1; i >= 0; i--) begin
            if (hit[i]) begin
                grant_idx = cand[i];
            end
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Round-robin GREEN -> YELLOW -> ALLRED phase scheduler for an N-approach
// intersection, with min-green, clearance timing and an all-red override.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int NUM_APPROACH = 4,
    parameter int MIN_GREEN    = 10,
    parameter int MAX_GREEN    = 30,
    parameter int YELLOW_TIME  = 3,
    parameter int ALLRED_TIME  = 2
) (
    input  logic                            clk,
    input  logic                            rstb,
    input  logic [NUM_APPROACH-1:0]         req,
    input  logic                            force_allred,
    output logic [NUM_APPROACH-1:0]         green,
    output logic [NUM_APPROACH-1:0]         yellow,
    output logic [NUM_APPROACH-1:0]         red,
    output logic [$clog2(NUM_APPROACH)-1:0] phase_id,
    output logic                            busy
);

    localparam int IDW = $clog2(NUM_APPROACH);
    localparam int CW  = $clog2(max_int(max_int(MAX_GREEN, YELLOW_TIME), ALLRED_TIME) + 1);

    localparam logic [CW-1:0]  MIN_LIM    = CW'(MIN_GREEN - 1);
    localparam logic [CW-1:0]  GREEN_LIM  = CW'(MAX_GREEN - 1);
    localparam logic [CW-1:0]  YELLOW_LIM = CW'(YELLOW_TIME - 1);
    localparam logic [CW-1:0]  ALLRED_LIM = CW'(ALLRED_TIME - 1);
    localparam logic [IDW-1:0] LAST_IDX   = IDW'(NUM_APPROACH - 1);

    phase_e                  state_reg;
    logic [CW-1:0]           cnt_reg;
    logic [CW-1:0]           cnt_limit;
    logic [CW-1:0]           cnt_step;
    logic [NUM_APPROACH-1:0] pending_reg;
    logic [NUM_APPROACH-1:0] latch_mask;
    logic [IDW-1:0]          last_grant_reg;
    logic [IDW-1:0]          phase_id_reg;
    logic [NUM_APPROACH-1:0] green_reg;
    logic [NUM_APPROACH-1:0] yellow_reg;
    logic [NUM_APPROACH-1:0] red_reg;
    logic                    busy_reg;

    logic                    pick_valid;
    logic [IDW-1:0]          pick_idx;
    logic [NUM_APPROACH-1:0] pick_onehot;
    logic                    grant_now;
    logic                    rival;

    traffic_rr_picker #(
        .NUM_APPROACH (NUM_APPROACH)
    ) u_picker (
        .pending    (pending_reg),
        .last_grant (last_grant_reg),
        .valid      (pick_valid),
        .grant_idx  (pick_idx)
    );

    assign pick_onehot = {{(NUM_APPROACH-1){1'b0}}, 1'b1} << pick_idx;
    assign grant_now   = (state_reg == ALLRED) && (cnt_reg >= ALLRED_LIM)
                       && !force_allred && pick_valid;
    assign rival       = |(pending_reg & ~green_reg);

    always_comb begin
        case (state_reg)
            GREEN:   cnt_limit = GREEN_LIM;
            YELLOW:  cnt_limit = YELLOW_LIM;
            default: cnt_limit = ALLRED_LIM;
        endcase
        cnt_step = (cnt_reg >= cnt_limit) ? cnt_reg : cnt_reg + CW'(1);
    end

    // The approach being served does not re-latch its own request.
    always_comb begin
        latch_mask = '0;
        if (state_reg == GREEN) begin
            latch_mask = green_reg;
        end else if (grant_now) begin
            latch_mask = pick_onehot;
        end
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            state_reg      <= ALLRED;
            cnt_reg        <= '0;
            pending_reg    <= '0;
            last_grant_reg <= LAST_IDX;
            phase_id_reg   <= '0;
            green_reg      <= '0;
            yellow_reg     <= '0;
            red_reg        <= '1;
            busy_reg       <= 1'b0;
        end else begin
            pending_reg <= (pending_reg | req) & ~latch_mask;
            case (state_reg)
                ALLRED: begin
                    if (grant_now) begin
                        state_reg      <= GREEN;
                        cnt_reg        <= '0;
                        last_grant_reg <= pick_idx;
                        phase_id_reg   <= pick_idx;
                        green_reg      <= pick_onehot;
                        red_reg        <= ~pick_onehot;
                        busy_reg       <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_step;
                    end
                end
                GREEN: begin
                    if (force_allred || ((cnt_reg >= MIN_LIM) && rival)) begin
                        state_reg  <= YELLOW;
                        cnt_reg    <= '0;
                        green_reg  <= '0;
                        yellow_reg <= green_reg;
                    end else begin
                        cnt_reg <= cnt_step;
                    end
                end
                YELLOW: begin
                    if (cnt_reg >= YELLOW_LIM) begin
                        state_reg  <= ALLRED;
                        cnt_reg    <= '0;
                        yellow_reg <= '0;
                        red_reg    <= '1;
                        busy_reg   <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_step;
                    end
                end
                default: begin
                    state_reg  <= ALLRED;
                    cnt_reg    <= '0;
                    green_reg  <= '0;
                    yellow_reg <= '0;
                    red_reg    <= '1;
                    busy_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign green    = green_reg;
    assign yellow   = yellow_reg;
    assign red      = red_reg;
    assign phase_id = phase_id_reg;
    assign busy     = busy_reg;

    // Safety invariants: at most one approach lit non-red, one colour per lamp.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            assert ($onehot0(green_reg | yellow_reg) && ((green_reg & yellow_reg) == '0));
        end
    end

    for (genvar gi = 0; gi < NUM_APPROACH; gi++) begin : g_lamp_chk
        always_ff @(posedge clk) begin
            if (!rstb) begin
                assert ({green_reg[gi], yellow_reg[gi], red_reg[gi]}
                        inside {LAMP_RED, LAMP_YELLOW, LAMP_GREEN});
            end
        end
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: vector table, directed corner sequences
// and randomized traffic checked against a behavioural model.
module tb_traffic_phase_scheduler;

    localparam int N     = 4;
    localparam int MIN_G = 4;
    localparam int MAX_G = 8;
    localparam int YEL   = 2;
    localparam int AR    = 1;

    logic         clk = 1'b0;
    logic         rstb = 1'b1;
    logic         force_allred = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] green, yellow, red;
    logic [1:0]   phase_id;
    logic         busy;

    int errors = 0;
    int checks = 0;

    traffic_phase_scheduler #(
        .NUM_APPROACH (N),
        .MIN_GREEN    (MIN_G),
        .MAX_GREEN    (MAX_G),
        .YELLOW_TIME  (YEL),
        .ALLRED_TIME  (AR)
    ) dut (
        .clk          (clk),
        .rstb         (rstb),
        .req          (req),
        .force_allred (force_allred),
        .green        (green),
        .yellow       (yellow),
        .red          (red),
        .phase_id     (phase_id),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase 0=all-red, 1=green, 2=yellow; m_time counts
    // cycles spent in the current phase without saturation.
    int         m_phase;
    int         m_time;
    logic [3:0] m_pend;
    int         m_last;
    int         m_id;

    task automatic model_step(input logic [3:0] r, input logic f, input logic s);
        logic [3:0] np;
        int         nxt;
        bit         found;
        if (s) begin
            m_phase = 0; m_time = 0; m_pend = '0; m_last = N - 1; m_id = 0;
            return;
        end
        np = m_pend | r;
        case (m_phase)
            0: begin
                if (m_time >= AR - 1 && !f && m_pend != 0) begin
                    found = 0;
                    nxt   = 0;
                    for (int k = 1; k <= N; k++) begin
                        if (!found && m_pend[2'((m_last + k) % N)]) begin
                            found = 1;
                            nxt   = (m_last + k) % N;
                        end
                    end
                    m_phase = 1; m_time = 0; m_id = nxt; m_last = nxt;
                    np[2'(nxt)] = 1'b0;
                end else begin
                    m_time++;
                end
            end
            1: begin
                np[2'(m_id)] = 1'b0;
                if (f || (m_time >= MIN_G - 1 && (m_pend & ~(4'b0001 << m_id)) != 0)) begin
                    m_phase = 2; m_time = 0;
                end else begin
                    m_time++;
                end
            end
            default: begin
                if (m_time >= YEL - 1) begin
                    m_phase = 0; m_time = 0;
                end else begin
                    m_time++;
                end
            end
        endcase
        m_pend = np;
    endtask

    function automatic logic [14:0] pack_exp(input logic [3:0] g, input logic [3:0] y,
                                             input logic [1:0] id);
        return {g, y, ~(g | y), id, |(g | y)};
    endfunction

    function automatic logic [14:0] model_exp();
        logic [3:0] g, y;
        g = (m_phase == 1) ? (4'b0001 << m_id) : 4'b0000;
        y = (m_phase == 2) ? (4'b0001 << m_id) : 4'b0000;
        return pack_exp(g, y, 2'(m_id));
    endfunction

    task automatic cycle(input logic [3:0] r, input logic f, input logic s);
        req = r; force_allred = f; rstb = s;
        @(posedge clk);
        model_step(r, f, s);
        #1;
    endtask

    task automatic check(input string name, input logic [14:0] exp);
        logic [14:0] act;
        act = {green, yellow, red, phase_id, busy};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got g=%b y=%b r=%b id=%0d busy=%b, want g=%b y=%b r=%b id=%0d busy=%b",
                     name, act[14:11], act[10:7], act[6:3], act[2:1], act[0],
                     exp[14:11], exp[10:7], exp[6:3], exp[2:1], exp[0]);
        end else begin
            $display("ok   %s: g=%b y=%b r=%b id=%0d busy=%b",
                     name, act[14:11], act[10:7], act[6:3], act[2:1], act[0]);
        end
    endtask

    task automatic step_chk(input string name, input logic [3:0] r, input logic f,
                            input logic s, input logic [3:0] g, input logic [3:0] y,
                            input logic [1:0] id);
        cycle(r, f, s);
        check(name, pack_exp(g, y, id));
    endtask

    typedef struct {
        logic [3:0] req;
        logic       frc;
        logic       rst;
        logic [3:0] g;
        logic [3:0] y;
        logic [1:0] id;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] r, input logic f, input logic s,
                       input logic [3:0] g, input logic [3:0] y, input int id);
        vec_t v;
        v.req = r; v.frc = f; v.rst = s; v.g = g; v.y = y; v.id = 2'(id);
        vecs.push_back(v);
    endtask

    initial begin
        logic       rand_frc;
        logic [3:0] oh;
        int         p, a;

        // Reset, idle, single request resting in green, then 4-way round robin.
        add(4'b0000, 0, 1, 4'b0000, 4'b0000, 0);
        for (int k = 0; k < 20; k++) add(4'b0000, 0, 0, 4'b0000, 4'b0000, 0);
        add(4'b0100, 0, 0, 4'b0000, 4'b0000, 0);
        for (int k = 0; k < 10; k++) add(4'b0000, 0, 0, 4'b0100, 4'b0000, 2);
        add(4'b0000, 0, 1, 4'b0000, 4'b0000, 0);
        add(4'b1111, 0, 0, 4'b0000, 4'b0000, 0);
        for (int k = 2; k <= 33; k++) begin
            p  = (k - 2) % (MIN_G + YEL + AR);
            a  = ((k - 2) / (MIN_G + YEL + AR)) % N;
            oh = 4'b0001 << a;
            if (p < MIN_G)            add(4'b1111, 0, 0, oh, 4'b0000, a);
            else if (p < MIN_G + YEL) add(4'b1111, 0, 0, 4'b0000, oh, a);
            else                      add(4'b1111, 0, 0, 4'b0000, 4'b0000, a);
        end

        foreach (vecs[i]) begin
            cycle(vecs[i].req, vecs[i].frc, vecs[i].rst);
            check($sformatf("vec%0d", i), pack_exp(vecs[i].g, vecs[i].y, vecs[i].id));
        end

        // Late rival after a long solo green.
        step_chk("t4_rst",   4'b0000, 0, 1, 4'b0000, 4'b0000, 0);
        step_chk("t4_req1",  4'b0010, 0, 0, 4'b0000, 4'b0000, 0);
        step_chk("t4_g1",    4'b0000, 0, 0, 4'b0010, 4'b0000, 1);
        for (int k = 0; k < 20; k++)
            step_chk($sformatf("t4_hold%0d", k), 4'b0000, 0, 0, 4'b0010, 4'b0000, 1);
        step_chk("t4_req3",  4'b1000, 0, 0, 4'b0010, 4'b0000, 1);
        step_chk("t4_y1a",   4'b0000, 0, 0, 4'b0000, 4'b0010, 1);
        step_chk("t4_y1b",   4'b0000, 0, 0, 4'b0000, 4'b0010, 1);
        step_chk("t4_ar",    4'b0000, 0, 0, 4'b0000, 4'b0000, 1);
        step_chk("t4_g3",    4'b0000, 0, 0, 4'b1000, 4'b0000, 3);

        // Override cuts green short and holds all-red.
        step_chk("t5_rst",   4'b0000, 0, 1, 4'b0000, 4'b0000, 0);
        step_chk("t5_req0",  4'b0001, 0, 0, 4'b0000, 4'b0000, 0);
        step_chk("t5_g0c0",  4'b0000, 0, 0, 4'b0001, 4'b0000, 0);
        step_chk("t5_g0c1",  4'b0000, 0, 0, 4'b0001, 4'b0000, 0);
        step_chk("t5_frc_y", 4'b0100, 1, 0, 4'b0000, 4'b0001, 0);
        step_chk("t5_y2",    4'b0000, 1, 0, 4'b0000, 4'b0001, 0);
        for (int k = 0; k < 4; k++)
            step_chk($sformatf("t5_hold%0d", k), 4'b0000, 1, 0, 4'b0000, 4'b0000, 0);
        step_chk("t5_rel",   4'b0000, 0, 0, 4'b0100, 4'b0000, 2);
        step_chk("t5_g2",    4'b0000, 0, 0, 4'b0100, 4'b0000, 2);

        // Reset during yellow discards pending requests.
        step_chk("t6_rst",   4'b0000, 0, 1, 4'b0000, 4'b0000, 0);
        step_chk("t6_req0",  4'b0001, 0, 0, 4'b0000, 4'b0000, 0);
        step_chk("t6_g0a",   4'b0000, 0, 0, 4'b0001, 4'b0000, 0);
        step_chk("t6_pend",  4'b1010, 0, 0, 4'b0001, 4'b0000, 0);
        step_chk("t6_g0b",   4'b0000, 0, 0, 4'b0001, 4'b0000, 0);
        step_chk("t6_g0c",   4'b0000, 0, 0, 4'b0001, 4'b0000, 0);
        step_chk("t6_y0",    4'b0000, 0, 0, 4'b0000, 4'b0001, 0);
        step_chk("t6_midrst",4'b0000, 0, 1, 4'b0000, 4'b0000, 0);
        for (int k = 0; k < 10; k++)
            step_chk($sformatf("t6_idle%0d", k), 4'b0000, 0, 0, 4'b0000, 4'b0000, 0);

        // Randomized traffic against the model.
        rand_frc = 1'b0;
        cycle(4'b0000, 0, 1);
        check("rand_rst", model_exp());
        for (int c = 0; c < 500; c++) begin
            logic [3:0] r;
            logic       s;
            r = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            if ($urandom_range(0, 24) == 0) rand_frc = ~rand_frc;
            s = ($urandom_range(0, 249) == 0);
            cycle(r, rand_frc, s);
            check($sformatf("rand%0d", c), model_exp());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
